chaotic_iter_ctrl: RTL and testbench
====================================

Name: chaotic_iter_ctrl

Overview:
- Iteration controller for the three-equation chaotic engine (x/y/z forward-Euler datapath).
- Drives the engine's current-state side (n_valid, xn/yn/zn) and consumes its next-state side (n1_valid, xn1/yn1/zn1).
- Feeds each result back as the next current state. Discards a programmable warm-up count, then streams states plus one extracted bit to the downstream M-sequence logic over valid/ready.

Parameters:
- DATA_WIDTH, 64, float word width; must match the engine and its floating-point IP.
- CNT_WIDTH, 32, width of the iteration and warm-up counters.
- BIT_SEL, 20, bit index used for out_bit extraction (0..DATA_WIDTH-1).
- TIMEOUT_CYC, 1024, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  async active-high reset.
- start  in  1  one-cycle pulse; loads seeds and counts, begins iterating.
- stop  in  1  one-cycle pulse; graceful abort.
- seed_x/seed_y/seed_z  in  DATA_WIDTH each  initial state, sampled on start.
- warmup  in  CNT_WIDTH  iterations to discard, sampled on start.
- num_iter  in  CNT_WIDTH  outputs to emit; 0 = free-running.
- n_valid  out  1  to engine; one-cycle issue pulse.
- xn/yn/zn  out  DATA_WIDTH each  to engine; current state.
- n1_valid  in  1  from engine; result valid.
- xn1/yn1/zn1  in  DATA_WIDTH each  from engine; next state.
- out_valid  out  1  downstream valid.
- out_ready  in  1  downstream ready.
- out_x/out_y/out_z  out  DATA_WIDTH each  emitted state.
- out_bit  out  1  out_x[BIT_SEL]^out_y[BIT_SEL]^out_z[BIT_SEL].
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse on normal completion.
- iter_cnt  out  CNT_WIDTH  emitted-output count.
- timeout  out  1  sticky watchdog flag.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high. On reset every output and register is 0 and the FSM is IDLE. Reset mid-operation aborts immediately; any in-flight engine result is ignored.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - start latches seeds into the state registers, latches warmup and num_iter, clears iter_cnt, the warm-up counter and timeout, then goes to ISSUE.
  - stop has no effect in IDLE.
- ISSUE:
  - n_valid=1 for exactly one cycle, then go to WAIT.
  - xn/yn/zn always equal the state registers and stay stable from ISSUE until n1_valid is accepted.
- WAIT:
  - The first n1_valid latches xn1/yn1/zn1 into the state registers.
  - If the warm-up counter is below warmup: increment it and go to ISSUE. The result is not emitted.
  - Otherwise: load out_x/out_y/out_z, go to HOLD.
  - n1_valid outside WAIT (including the ISSUE cycle) is ignored.
- HOLD:
  - out_valid=1; outputs stay stable until out_valid&out_ready. This is the handshake cycle.
  - On handshake, iter_cnt increments.
  - If num_iter≠0 and the new iter_cnt==num_iter: pulse done, go to IDLE. Otherwise go to ISSUE (back-to-back possible; ISSUE occurs the cycle after the handshake).
- Issue latency: the first n_valid is asserted 1 cycle after start. Iteration rate = engine latency + 2 cycles + any HOLD stall.
- stop:
  - In ISSUE or HOLD: go to IDLE next cycle; out_valid drops with no handshake.
  - In WAIT: set a stop-pending flag, drain until n1_valid, latch the result into the state registers, go to IDLE without emitting.
  - done does not pulse on stop.
- start while busy is ignored. start and stop in the same cycle in IDLE: start wins.
- warmup=0 means no discard. Counters do not wrap in free-running mode: iter_cnt saturates at all-ones.
- Data is opaque: the block performs no arithmetic on state values; it only registers and routes them.

Optional Feature:
- Macro: CHAOS_ITER_TIMEOUT_EN.
- Defined: a watchdog counts cycles in WAIT. If it reaches TIMEOUT_CYC without n1_valid, set timeout=1 (sticky, cleared by start or rst) and go to IDLE. The engine is not reset; a late n1_valid is ignored.
- Undefined: WAIT waits indefinitely and timeout is tied to 0.

Decomposition:
- Shared package chaos_pkg holds:
  - the FSM state enum (IDLE/ISSUE/WAIT/HOLD);
  - default DATA_WIDTH=64 and CNT_WIDTH=32 constants;
  - the BIT_SEL default.
- One natural sub-module, chaos_out_stage: the HOLD register slice, i.e. out_* registers, valid/ready and out_bit XOR.

Test Plan:
- Bench uses an engine model that returns x+1.0, y+2.0, z+3.0 after 5 cycles.
- Basic run: seeds (0,0,0), warmup=0, num_iter=3, out_ready=1 -> outputs (1,2,3), (2,4,6), (3,6,9); done pulses once; iter_cnt=3; n_valid asserted exactly 3 times.
- Warm-up: warmup=2, num_iter=1 -> a single output (3,6,9); n_valid asserted 3 times.
- Backpressure: out_ready=0 for 10 cycles in HOLD -> out_* stable, no new n_valid; first output only after out_ready rises.
- stop in WAIT -> no n_valid after the drain; returns to IDLE after the model's n1_valid; no out_valid, no done.
- Reset mid-WAIT, then a late n1_valid -> all outputs 0, FSM IDLE, late result ignored.
- With CHAOS_ITER_TIMEOUT_EN and an engine model that never responds -> timeout=1 at TIMEOUT_CYC cycles after ISSUE; busy=0; next start clears timeout.

Source files
------------

// File: rtl/chaos_pkg.sv
`default_nettype none
// ============================================================================
// Module : chaos_pkg
// Shared FSM state type and default widths for the chaotic iteration controller.
// Rev    : 1.0
// ============================================================================
package chaos_pkg;

  localparam int DATA_WIDTH_DEF = 64;
  localparam int CNT_WIDTH_DEF  = 32;
  localparam int BIT_SEL_DEF    = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/chaos_out_stage.sv
`default_nettype none
// ============================================================================
// Module : chaos_out_stage
// Output register slice: holds the emitted state under valid/ready, derives out_bit.
// Rev    : 1.0
// ============================================================================
module chaos_out_stage
  import chaos_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int BIT_SEL    = BIT_SEL_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] in_x,
  input  logic [DATA_WIDTH-1:0] in_y,
  input  logic [DATA_WIDTH-1:0] in_z,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_x,
  output logic [DATA_WIDTH-1:0] out_y,
  output logic [DATA_WIDTH-1:0] out_z,
  output logic                  out_bit,
  output logic                  fire
);

  assign fire    = out_valid & out_ready;
  assign out_bit = out_x[BIT_SEL] ^ out_y[BIT_SEL] ^ out_z[BIT_SEL];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_z     <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_x     <= in_x;
      out_y     <= in_y;
      out_z     <= in_z;
    end else if (fire) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/chaotic_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module : chaotic_iter_ctrl
// Iteration controller for the x/y/z chaotic engine; optional WAIT watchdog via CHAOS_ITER_TIMEOUT_EN.
// Rev    : 1.0
// ============================================================================
module chaotic_iter_ctrl
  import chaos_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int BIT_SEL     = BIT_SEL_DEF,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [DATA_WIDTH-1:0] seed_x,
  input  logic [DATA_WIDTH-1:0] seed_y,
  input  logic [DATA_WIDTH-1:0] seed_z,
  input  logic [CNT_WIDTH-1:0]  warmup,
  input  logic [CNT_WIDTH-1:0]  num_iter,
  output logic                  n_valid,
  output logic [DATA_WIDTH-1:0] xn,
  output logic [DATA_WIDTH-1:0] yn,
  output logic [DATA_WIDTH-1:0] zn,
  input  logic                  n1_valid,
  input  logic [DATA_WIDTH-1:0] xn1,
  input  logic [DATA_WIDTH-1:0] yn1,
  input  logic [DATA_WIDTH-1:0] zn1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_x,
  output logic [DATA_WIDTH-1:0] out_y,
  output logic [DATA_WIDTH-1:0] out_z,
  output logic                  out_bit,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  iter_cnt,
  output logic                  timeout
);

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] sx, sy, sz;
  logic [CNT_WIDTH-1:0]  warmup_q, num_iter_q, warm_cnt, iter_cnt_q, iter_nxt;
  logic                  stop_pend, done_q;
  logic                  do_start, take_res, warm_inc, out_load, out_clear;
  logic                  accept, finish, set_pend, wd_hit, fire;

  assign n_valid  = (state == ST_ISSUE);
  assign busy     = (state != ST_IDLE);
  assign xn       = sx;
  assign yn       = sy;
  assign zn       = sz;
  assign iter_cnt = iter_cnt_q;
  assign done     = done_q;

  // Saturating count so free-running mode never wraps.
  assign iter_nxt = (&iter_cnt_q) ? iter_cnt_q : iter_cnt_q + CNT_WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_start  = 1'b0;
    take_res  = 1'b0;
    warm_inc  = 1'b0;
    out_load  = 1'b0;
    out_clear = 1'b0;
    accept    = 1'b0;
    finish    = 1'b0;
    set_pend  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          do_start  = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_nxt = stop ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (n1_valid) begin
          take_res = 1'b1;
          // A stop arriving together with the result still drains without emitting.
          if (stop_pend || stop) begin
            state_nxt = ST_IDLE;
          end else if (warm_cnt < warmup_q) begin
            warm_inc  = 1'b1;
            state_nxt = ST_ISSUE;
          end else begin
            out_load  = 1'b1;
            state_nxt = ST_HOLD;
          end
        end else begin
          set_pend = stop;
          if (wd_hit) state_nxt = ST_IDLE;
        end
      end
      ST_HOLD: begin
        // Stop has priority over a coincident handshake: the word is dropped uncounted.
        if (stop) begin
          out_clear = 1'b1;
          state_nxt = ST_IDLE;
        end else if (fire) begin
          accept = 1'b1;
          if ((num_iter_q != '0) && (iter_nxt == num_iter_q)) begin
            finish    = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_ISSUE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sx         <= '0;
      sy         <= '0;
      sz         <= '0;
      warmup_q   <= '0;
      num_iter_q <= '0;
      warm_cnt   <= '0;
      iter_cnt_q <= '0;
      stop_pend  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= finish;
      if (do_start) begin
        sx         <= seed_x;
        sy         <= seed_y;
        sz         <= seed_z;
        warmup_q   <= warmup;
        num_iter_q <= num_iter;
        warm_cnt   <= '0;
        iter_cnt_q <= '0;
      end
      if (take_res) begin
        sx <= xn1;
        sy <= yn1;
        sz <= zn1;
      end
      if (warm_inc) warm_cnt <= warm_cnt + CNT_WIDTH'(1);
      if (accept)   iter_cnt_q <= iter_nxt;
      if (set_pend) stop_pend <= 1'b1;
      if (state_nxt == ST_IDLE) stop_pend <= 1'b0;
    end
  end

`ifdef CHAOS_ITER_TIMEOUT_EN
  // wd_cnt is 0 in ISSUE and the first WAIT cycle, so the flag rises TIMEOUT_CYC cycles after ISSUE.
  localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 2);

  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;

  assign wd_hit  = (state == ST_WAIT) && !n1_valid && (wd_cnt == WD_LAST);
  assign timeout = timeout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if ((state == ST_WAIT) && !n1_valid) wd_cnt <= wd_cnt + WD_W'(1);
      else                                 wd_cnt <= '0;
      if (do_start)    timeout_q <= 1'b0;
      else if (wd_hit) timeout_q <= 1'b1;
    end
  end
`else
  assign wd_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  chaos_out_stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .BIT_SEL    (BIT_SEL)
  ) u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (out_load),
    .clear     (out_clear),
    .in_x      (xn1),
    .in_y      (yn1),
    .in_z      (zn1),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_z     (out_z),
    .out_bit   (out_bit),
    .fire      (fire)
  );

endmodule
`default_nettype wire

// File: tb/tb_chaotic_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_chaotic_iter_ctrl
// Self-checking bench with a 5-cycle +1/+2/+3 engine model and an output scoreboard.
// Rev    : 1.0
// ============================================================================
module tb_chaotic_iter_ctrl;

  localparam int DW  = 64;
  localparam int CW  = 32;
  localparam int BS  = 20;
  localparam int TO  = 1024;
  localparam int LAT = 5;

  logic          clk = 1'b0;
  logic          rst, start, stop, n1_valid, out_ready;
  logic [DW-1:0] seed_x, seed_y, seed_z, xn1, yn1, zn1;
  logic [CW-1:0] warmup, num_iter;
  logic          n_valid, out_valid, out_bit, busy, done, timeout;
  logic [DW-1:0] xn, yn, zn, out_x, out_y, out_z;
  logic [CW-1:0] iter_cnt;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  chaotic_iter_ctrl #(
    .DATA_WIDTH (DW), .CNT_WIDTH (CW), .BIT_SEL (BS), .TIMEOUT_CYC (TO)
  ) dut (
    .clk (clk), .rst (rst), .start (start), .stop (stop),
    .seed_x (seed_x), .seed_y (seed_y), .seed_z (seed_z),
    .warmup (warmup), .num_iter (num_iter),
    .n_valid (n_valid), .xn (xn), .yn (yn), .zn (zn),
    .n1_valid (n1_valid), .xn1 (xn1), .yn1 (yn1), .zn1 (zn1),
    .out_valid (out_valid), .out_ready (out_ready),
    .out_x (out_x), .out_y (out_y), .out_z (out_z), .out_bit (out_bit),
    .busy (busy), .done (done), .iter_cnt (iter_cnt), .timeout (timeout)
  );

  typedef struct { logic [DW-1:0] x, y, z; int due; } resp_t;
  typedef struct { logic [DW-1:0] x, y, z; } exp_t;

  resp_t eng_q[$];
  exp_t  exp_q[$];
  bit    eng_on = 1'b1;
  int    n_cmp = 0, n_bad = 0;
  int    nv_cnt, nv_last, nv_period, done_cnt, hs_cnt, ov_cnt;

  // Engine model: returns (x+1, y+2, z+3) LAT cycles after each n_valid.
  always @(negedge clk) begin : engine
    resp_t r;
    n1_valid = 1'b0;
    if (eng_q.size() > 0 && eng_q[0].due <= cyc) begin
      r = eng_q.pop_front();
      xn1 = r.x; yn1 = r.y; zn1 = r.z;
      n1_valid = 1'b1;
    end
    if (n_valid === 1'b1 && eng_on) begin
      r.x = $realtobits($bitstoreal(xn) + 1.0);
      r.y = $realtobits($bitstoreal(yn) + 2.0);
      r.z = $realtobits($bitstoreal(zn) + 3.0);
      r.due = cyc + LAT;
      eng_q.push_back(r);
    end
  end

  // Event counters and scoreboard checking of every handshake.
  always @(negedge clk) begin : monitor
    exp_t e;
    #1;
    if (n_valid === 1'b1) begin
      nv_cnt++;
      nv_period = cyc - nv_last;
      nv_last   = cyc;
    end
    if (done === 1'b1) done_cnt++;
    if (out_valid === 1'b1) ov_cnt++;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      hs_cnt++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output: got x=%h y=%h z=%h, required no output", out_x, out_y, out_z);
      end else begin
        e = exp_q.pop_front();
        if (out_x !== e.x || out_y !== e.y || out_z !== e.z) begin
          n_bad++;
          $display("FAIL out_data: got %h/%h/%h, required %h/%h/%h", out_x, out_y, out_z, e.x, e.y, e.z);
        end
        n_cmp++;
        if (out_bit !== (e.x[BS] ^ e.y[BS] ^ e.z[BS])) begin
          n_bad++;
          $display("FAIL out_bit: got %b, required %b", out_bit, e.x[BS] ^ e.y[BS] ^ e.z[BS]);
        end
      end
    end
  end

  function automatic void push_exp(input real x, input real y, input real z);
    exp_t e;
    e.x = $realtobits(x); e.y = $realtobits(y); e.z = $realtobits(z);
    exp_q.push_back(e);
  endfunction

  task automatic zero_counts();
    nv_cnt = 0; done_cnt = 0; hs_cnt = 0; ov_cnt = 0;
  endtask

  // Returns at the negedge of the ISSUE cycle.
  task automatic run_start(input real x, input real y, input real z, input int w, input int n);
    @(negedge clk);
    seed_x = $realtobits(x); seed_y = $realtobits(y); seed_z = $realtobits(z);
    warmup = w; num_iter = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
    #2;
  endtask

  task automatic wait_out_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; out_ready = 1'b0;
    seed_x = '0; seed_y = '0; seed_z = '0; warmup = '0; num_iter = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, n_valid, out_valid, done, timeout} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got busy/nv/ov/done/to=%b, required 00000", {busy, n_valid, out_valid, done, timeout});
    end
    n_cmp++;
    if (iter_cnt !== '0 || xn !== '0 || out_x !== '0 || out_bit !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_data: got iter_cnt=%0d xn=%h out_x=%h, required 0", iter_cnt, xn, out_x);
    end
  endtask

  task automatic test_basic();
    bit ok;
    zero_counts();
    out_ready = 1'b1;
    push_exp(1.0, 2.0, 3.0); push_exp(2.0, 4.0, 6.0); push_exp(3.0, 6.0, 9.0);
    run_start(0.0, 0.0, 0.0, 0, 3);
    n_cmp++;
    if (n_valid !== 1'b1) begin
      n_bad++; $display("FAIL issue_latency: got n_valid=%b one cycle after start, required 1", n_valid);
    end
    repeat (3) @(negedge clk);
    seed_x = $realtobits(9.0); start = 1'b1;   // ignored while busy
    @(negedge clk);
    start = 1'b0;
    wait_idle(100, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL basic_idle: got busy=1 after 100 cycles, required 0"); end
    n_cmp++;
    if (done_cnt !== 1) begin n_bad++; $display("FAIL basic_done: got %0d pulses, required 1", done_cnt); end
    n_cmp++;
    if (iter_cnt !== 3) begin n_bad++; $display("FAIL basic_iter_cnt: got %0d, required 3", iter_cnt); end
    n_cmp++;
    if (nv_cnt !== 3) begin n_bad++; $display("FAIL basic_n_valid: got %0d, required 3", nv_cnt); end
    n_cmp++;
    if (nv_period !== LAT + 2) begin n_bad++; $display("FAIL basic_rate: got %0d cycles, required %0d", nv_period, LAT + 2); end
    n_cmp++;
    if (hs_cnt !== 3 || exp_q.size() !== 0) begin
      n_bad++; $display("FAIL basic_outputs: got %0d handshakes, %0d left, required 3/0", hs_cnt, exp_q.size());
    end
  endtask

  task automatic test_warmup();
    bit ok;
    zero_counts();
    out_ready = 1'b1;
    push_exp(3.0, 6.0, 9.0);
    run_start(0.0, 0.0, 0.0, 2, 1);
    wait_idle(100, ok);
    n_cmp++;
    if (!ok || nv_cnt !== 3) begin n_bad++; $display("FAIL warmup_n_valid: got %0d (idle=%b), required 3", nv_cnt, ok); end
    n_cmp++;
    if (hs_cnt !== 1 || done_cnt !== 1 || iter_cnt !== 1) begin
      n_bad++; $display("FAIL warmup_outputs: got hs=%0d done=%0d iter=%0d, required 1/1/1", hs_cnt, done_cnt, iter_cnt);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int nvs;
    real x1, y1, z1;
    zero_counts();
    out_ready = 1'b0;
    x1 = 0.1 + 1.0; y1 = 0.2 + 2.0; z1 = 0.3 + 3.0;
    push_exp(x1, y1, z1); push_exp(x1 + 1.0, y1 + 2.0, z1 + 3.0);
    run_start(0.1, 0.2, 0.3, 0, 2);
    wait_out_valid(50, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL bp_out_valid: got no out_valid in 50 cycles, required 1"); end
    #2 nvs = nv_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_x !== $realtobits(x1) || out_y !== $realtobits(y1) || out_z !== $realtobits(z1)) begin
        n_bad++; $display("FAIL bp_hold: cycle %0d got ov=%b x=%h, required 1/%h", i, out_valid, out_x, $realtobits(x1));
      end
    end
    #2;
    n_cmp++;
    if (nv_cnt !== nvs || hs_cnt !== 0) begin
      n_bad++; $display("FAIL bp_stall: got n_valid %0d->%0d hs=%0d, required no change/0", nvs, nv_cnt, hs_cnt);
    end
    @(negedge clk);
    out_ready = 1'b1;
    wait_idle(100, ok);
    n_cmp++;
    if (!ok || hs_cnt !== 2 || exp_q.size() !== 0) begin
      n_bad++; $display("FAIL bp_release: got hs=%0d left=%0d, required 2/0", hs_cnt, exp_q.size());
    end
  endtask

  task automatic test_stop_wait();
    bit ok;
    zero_counts();
    out_ready = 1'b1;
    run_start(0.0, 0.0, 0.0, 0, 0);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL stopw_drain: got busy=%b before result, required 1", busy); end
    wait_idle(30, ok);
    repeat (5) @(negedge clk);
    #2;
    n_cmp++;
    if (!ok || eng_q.size() !== 0) begin n_bad++; $display("FAIL stopw_idle: got idle=%b pending=%0d, required 1/0", ok, eng_q.size()); end
    n_cmp++;
    if (nv_cnt !== 1 || ov_cnt !== 0 || done_cnt !== 0) begin
      n_bad++; $display("FAIL stopw_quiet: got nv=%0d ov=%0d done=%0d, required 1/0/0", nv_cnt, ov_cnt, done_cnt);
    end
    n_cmp++;
    if (xn !== $realtobits(1.0)) begin n_bad++; $display("FAIL stopw_latch: got xn=%h, required %h", xn, $realtobits(1.0)); end
  endtask

  task automatic test_stop_hold();
    bit ok;
    zero_counts();
    out_ready = 1'b0;
    run_start(0.0, 0.0, 0.0, 0, 0);
    wait_out_valid(50, ok);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    #2;
    n_cmp++;
    if (!ok || out_valid !== 1'b0 || busy !== 1'b0 || hs_cnt !== 0 || done_cnt !== 0) begin
      n_bad++; $display("FAIL stoph: got ov=%b busy=%b hs=%0d done=%0d, required 0/0/0/0", out_valid, busy, hs_cnt, done_cnt);
    end
  endtask

  task automatic test_reset_mid_wait();
    zero_counts();
    out_ready = 1'b1;
    run_start(0.5, 0.5, 0.5, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || n_valid !== 1'b0 || xn !== '0 || out_valid !== 1'b0 || iter_cnt !== '0) begin
      n_bad++; $display("FAIL rstw_clear: got busy=%b nv=%b xn=%h ov=%b, required all 0", busy, n_valid, xn, out_valid);
    end
    rst = 1'b0;
    repeat (8) @(negedge clk);
    #2;
    n_cmp++;
    if (busy !== 1'b0 || xn !== '0 || ov_cnt !== 0 || eng_q.size() !== 0) begin
      n_bad++; $display("FAIL rstw_late: got busy=%b xn=%h ov=%0d pending=%0d, required 0/0/0/0", busy, xn, ov_cnt, eng_q.size());
    end
  endtask

`ifdef CHAOS_ITER_TIMEOUT_EN
  task automatic test_timeout();
    bit ok, hit;
    int t_issue, t_to;
    zero_counts();
    out_ready = 1'b1;
    eng_on = 1'b0;
    run_start(0.0, 0.0, 0.0, 0, 1);
    t_issue = cyc;
    hit = 1'b0; t_to = 0;
    for (int i = 0; i < TO + 50; i++) begin
      @(negedge clk);
      if (timeout === 1'b1) begin hit = 1'b1; t_to = cyc; break; end
    end
    n_cmp++;
    if (!hit || (t_to - t_issue) !== TO || busy !== 1'b0) begin
      n_bad++; $display("FAIL timeout_set: got hit=%b after %0d cycles busy=%b, required 1/%0d/0", hit, t_to - t_issue, busy, TO);
    end
    eng_on = 1'b1;
    push_exp(1.0, 2.0, 3.0);
    run_start(0.0, 0.0, 0.0, 0, 1);
    n_cmp++;
    if (timeout !== 1'b0) begin n_bad++; $display("FAIL timeout_clear: got %b after start, required 0", timeout); end
    wait_idle(100, ok);
    n_cmp++;
    if (!ok || hs_cnt !== 1) begin n_bad++; $display("FAIL timeout_rerun: got hs=%0d, required 1", hs_cnt); end
  endtask
`else
  task automatic test_timeout();
    zero_counts();
    out_ready = 1'b1;
    eng_on = 1'b0;
    run_start(0.0, 0.0, 0.0, 0, 1);
    repeat (50) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || timeout !== 1'b0) begin
      n_bad++; $display("FAIL no_watchdog: got busy=%b timeout=%b, required 1/0", busy, timeout);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    eng_on = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_warmup();
    test_backpressure();
    test_stop_wait();
    test_stop_hold();
    test_reset_mid_wait();
    test_timeout();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no completion by 500000, required finish");
    $fatal(1, "bench time limit");
  end

endmodule
`default_nettype wire
